// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush scheduler for the 5-stage RV32 pipeline: RAW detection, ID forwarding,
// branch redirect and halt-drain sequencing. Optional perf counters behind `PERF_CNT_EN`.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned REDIR_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_is_branch,
  input  logic       id_take,
  input  logic       id_halt_req,
  input  logic       ex_valid,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       ex_busy,
  input  logic       resume,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_if,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2,
  output logic       halted,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_halt_cyc,
`endif
  output logic [1:0] state
);

  localparam int unsigned RCNT_W = 2;
  localparam logic [RCNT_W-1:0] REDIR_LOAD = RCNT_W'(REDIR_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REDIR  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [RCNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic              halted_q, halted_d;

  function automatic logic src_match(input logic use_r, input logic [4:0] r,
                                     input logic pvalid, input logic pwrite,
                                     input logic [4:0] prd);
    return use_r && (r != 5'd0) && pvalid && pwrite && (prd == r);
  endfunction

  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic haz;

  // Producer matches and RAW hazard against the ID operands.
  always_comb begin
    ex_m1  = src_match(id_use_rs1, id_rs1, ex_valid,  ex_regwrite,  ex_rd);
    ex_m2  = src_match(id_use_rs2, id_rs2, ex_valid,  ex_regwrite,  ex_rd);
    mem_m1 = src_match(id_use_rs1, id_rs1, mem_valid, mem_regwrite, mem_rd);
    mem_m2 = src_match(id_use_rs2, id_rs2, mem_valid, mem_regwrite, mem_rd);
    wb_m1  = src_match(id_use_rs1, id_rs1, wb_valid,  wb_regwrite,  wb_rd);
    wb_m2  = src_match(id_use_rs2, id_rs2, wb_valid,  wb_regwrite,  wb_rd);
    haz = id_valid && (((ex_m1 || ex_m2) && (ex_memread || id_is_branch)) ||
                       ((mem_m1 || mem_m2) && mem_memread && id_is_branch));
  end

  // Forwarding select: a non-load MEM result is youngest, so it wins over WB.
  always_comb begin
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    if (mem_m1 && !mem_memread) fwd_rs1 = 2'b01;
    else if (wb_m1)             fwd_rs1 = 2'b10;
    if (mem_m2 && !mem_memread) fwd_rs2 = 2'b01;
    else if (wb_m2)             fwd_rs2 = 2'b10;
  end

  // Scheduler next-state and pipeline control.
  always_comb begin
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ex_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end else if (haz) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (id_valid && id_take) begin
          flush_if    = 1'b1;
          redir_cnt_d = REDIR_LOAD;
          if (REDIR_CYC > 1) state_d = ST_REDIR;
        end else if (id_valid && id_halt_req) begin
          // Halt instruction is held in ID and never issued.
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_REDIR: begin
        flush_if = 1'b1;
        if (redir_cnt_q <= RCNT_W'(1)) begin
          redir_cnt_d = '0;
          state_d     = ST_RUN;
        end else begin
          redir_cnt_d = redir_cnt_q - RCNT_W'(1);
        end
      end
      ST_DRAIN: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        if (!(ex_valid || mem_valid || wb_valid || ex_busy)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
        if (resume) begin
          // PC stays held; IF/ID is overwritten with a bubble to retire the halt.
          flush_if = 1'b1;
          state_d  = ST_RUN;
        end else begin
          stall_id = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      redir_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign halted = halted_q;
  assign state  = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic [CNT_W-1:0] perf_halt_q,  perf_halt_d;

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_halt_d  = perf_halt_q;
    if ((state_q == ST_RUN) && stall_id && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + CNT_W'(1);
    if (flush_if && (perf_flush_q != '1))
      perf_flush_d = perf_flush_q + CNT_W'(1);
    if ((state_q == ST_HALTED) && (perf_halt_q != '1))
      perf_halt_d = perf_halt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_halt_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_halt_q  <= perf_halt_d;
    end
  end

  assign perf_stall    = perf_stall_q;
  assign perf_flush    = perf_flush_q;
  assign perf_halt_cyc = perf_halt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl, built with REDIR_CYC=2.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  logic       clk, rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_is_branch, id_take, id_halt_req;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_valid, ex_regwrite, ex_memread;
  logic       mem_valid, mem_regwrite, mem_memread;
  logic       wb_valid, wb_regwrite, ex_busy, resume;
  logic       stall_if, stall_id, bubble_ex, flush_if, halted;
  logic [1:0] fwd_rs1, fwd_rs2, state;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall, perf_flush, perf_halt_cyc;
`endif

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .REDIR_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .id_take(id_take), .id_halt_req(id_halt_req),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .ex_busy(ex_busy), .resume(resume),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .halted(halted),
`ifdef PERF_CNT_EN
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_halt_cyc(perf_halt_cyc),
`endif
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [10:0] ev(input logic si, input logic sd, input logic bx,
                                     input logic fl, input logic [1:0] f1,
                                     input logic [1:0] f2, input logic h,
                                     input logic [1:0] st);
    return {si, sd, bx, fl, f1, f2, h, st};
  endfunction

  task automatic check(input string tag, input logic [10:0] e);
    exp_t item, got;
    logic [10:0] obs;
    item.tag = tag;
    item.v   = e;
    exp_q.push_back(item);
    @(negedge clk);
    got = exp_q.pop_front();
    obs = {stall_if, stall_id, bubble_ex, flush_if, fwd_rs1, fwd_rs2, halted, state};
    n_vec++;
    assert (obs === got.v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (si sd bx fl f1 f2 h st)", got.tag, obs, got.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_branch = 0; id_take = 0; id_halt_req = 0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_valid = 0; mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_valid = 0; wb_regwrite = 0; wb_rd = 0; ex_busy = 0; resume = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    check("reset", ev(0,0,0,0,2'b00,2'b00,0,2'd0));
    tick();
    rst_n = 1'b1;

    // Load-use into a branch: EX, then MEM, then WB forwarding.
    id_valid = 1; id_is_branch = 1; id_rs1 = 5; id_rs2 = 6; id_use_rs1 = 1; id_use_rs2 = 1;
    ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 5;
    check("lw_ex_beq", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();
    ex_valid = 0; mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 5;
    check("lw_mem_beq", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();
    mem_valid = 0; wb_valid = 1; wb_regwrite = 1; wb_rd = 5;
    check("lw_wb_beq", ev(0,0,0,0,2'b10,2'b00,0,2'd0));
    tick();

    // ALU forwarding, MEM over WB, branch vs EX producer, x0.
    clr();
    id_valid = 1; id_rs1 = 7; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 7;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 7;
    check("fwd_mem_over_wb", ev(0,0,0,0,2'b01,2'b01,0,2'd0));
    tick();
    ex_valid = 1; ex_regwrite = 1; ex_rd = 7;
    check("alu_ex_no_haz", ev(0,0,0,0,2'b01,2'b01,0,2'd0));
    tick();
    id_is_branch = 1;
    check("alu_ex_branch_haz", ev(1,1,1,0,2'b01,2'b01,0,2'd0));
    tick();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    check("x0_no_fwd", ev(0,0,0,0,2'b00,2'b00,0,2'd0));
    tick();

    // Taken jump with two wrong-path cycles.
    clr();
    id_valid = 1; id_take = 1;
    check("take_run", ev(0,0,0,1,2'b00,2'b00,0,2'd0));
    tick();
    id_take = 0;
    check("take_redir", ev(0,0,0,1,2'b00,2'b00,0,2'd1));
    tick();
    check("take_back_run", ev(0,0,0,0,2'b00,2'b00,0,2'd0));
    tick();

    // Take while hazard is pending is deferred.
    id_take = 1; id_is_branch = 1; id_rs1 = 5; id_use_rs1 = 1;
    ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 5;
    check("take_haz_ignored", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();
    ex_valid = 0;
    check("take_after_haz", ev(0,0,0,1,2'b00,2'b00,0,2'd0));
    tick();
    id_take = 0;
    check("take2_redir", ev(0,0,0,1,2'b00,2'b00,0,2'd1));
    tick();

    // Multi-cycle EX op dominates a hazard.
    ex_valid = 1; ex_busy = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("busy_%0d", i), ev(1,1,0,0,2'b00,2'b00,0,2'd0));
      tick();
    end
    ex_busy = 0;
    check("busy_done_haz", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();

    // ebreak: hazard first, then drain three in-flight instructions.
    id_take = 0; id_halt_req = 1;
    check("halt_haz_first", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();
    clr();
    id_valid = 1; id_halt_req = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    check("halt_detect", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();
    ex_valid = 0;
    check("drain_1", ev(1,1,1,0,2'b00,2'b00,0,2'd2));
    tick();
    mem_valid = 0;
    check("drain_2", ev(1,1,1,0,2'b00,2'b00,0,2'd2));
    tick();
    wb_valid = 0;
    check("drain_3", ev(1,1,1,0,2'b00,2'b00,0,2'd2));
    tick();
    check("halted_1", ev(1,1,1,0,2'b00,2'b00,1,2'd3));
    tick();
    check("halted_2", ev(1,1,1,0,2'b00,2'b00,1,2'd3));
    tick();
    resume = 1;
    check("resume", ev(1,0,1,1,2'b00,2'b00,1,2'd3));
    tick();
    clr();
    resume = 1;
    check("run_resume_ignored", ev(0,0,0,0,2'b00,2'b00,0,2'd0));
    tick();
    resume = 0;
    check("run_after_resume", ev(0,0,0,0,2'b00,2'b00,0,2'd0));
    tick();

    // Asynchronous reset while draining.
    id_valid = 1; id_halt_req = 1; ex_valid = 1;
    check("halt2_detect", ev(1,1,1,0,2'b00,2'b00,0,2'd0));
    tick();
    check("drain2", ev(1,1,1,0,2'b00,2'b00,0,2'd2));
    tick();
    rst_n = 1'b0;
    clr();
    check("reset_in_drain", ev(0,0,0,0,2'b00,2'b00,0,2'd0));
`ifdef PERF_CNT_EN
    n_vec++;
    assert ({perf_stall, perf_flush, perf_halt_cyc} === '0) else begin
      n_err++;
      $error("FAIL perf_reset: observed %0d/%0d/%0d expected 0/0/0",
             perf_stall, perf_flush, perf_halt_cyc);
    end
`endif
    tick();
    rst_n = 1'b1;
    check("post_reset", ev(0,0,0,0,2'b00,2'b00,0,2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
